// File: rtl/transceiver_ack_nack_generator.sv
// Receiver-side TLP acknowledge responder: checks per-TLP ID/CRC results
// against the expected sequence ID and queues ACK/NACK DLLPs for transmit.
module transceiver_ack_nack_generator #(
    parameter int         TLP_ID_WIDTH   = 3,
    parameter int         DLLP_WIDTH     = 16,
    parameter logic [7:0] DLLP_TYPE_ACK  = 8'h01,
    parameter logic [7:0] DLLP_TYPE_NACK = 8'h02,
    parameter int         ACK_COALESCE   = 4,
    parameter int         ACK_TIMEOUT    = 64
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_link_up,
    input  logic                    i_rx_id_result_valid,
    input  logic [TLP_ID_WIDTH:0]   i_rx_id_result,
    output logic                    o_rx_id_result_rd,
    input  logic                    i_tx_dllp_rdy,
    output logic                    o_tx_dllp_wr,
    output logic [DLLP_WIDTH-1:0]   o_tx_dllp,
    output logic [TLP_ID_WIDTH-1:0] o_exp_id,
    output logic                    o_nack_active
);

    localparam int W    = TLP_ID_WIDTH;
    localparam int CW   = $clog2(ACK_COALESCE + 1);
    localparam int TW   = $clog2(ACK_TIMEOUT + 1);
    localparam int PADW = DLLP_WIDTH - 8 - W;

    localparam logic [CW-1:0] CNT_FORCE = CW'(ACK_COALESCE);
    localparam logic [TW-1:0] TIMER_MAX = TW'(ACK_TIMEOUT - 1);
    localparam logic [W-1:0]  DUP_MAX   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_SEND_ACK,
        S_SEND_NACK
    } state_t;

    state_t                r_state;
    logic [W-1:0]          r_exp_id;
    logic [W-1:0]          r_last_good;
    logic                  r_ack_pend;
    logic [CW-1:0]         r_ack_cnt;
    logic [TW-1:0]         r_timer;
    logic                  r_nack_flag;
    logic [W-1:0]          r_res_id;
    logic                  r_res_crc;
    logic                  r_rd;
    logic                  r_wr;
    logic [DLLP_WIDTH-1:0] r_dllp;

    state_t        w_next;
    logic          w_capture;
    logic          w_eval_good;
    logic          w_eval_dup;
    logic          w_ack_done;
    logic          w_nack_done;
    logic [W-1:0]  w_dist;
    logic [CW-1:0] w_cnt_inc;
    logic          w_is_good;
    logic          w_is_dup;
    logic          w_timeout;

    // Distance back from the expected ID; 1..half-window means already seen.
    assign w_dist    = r_exp_id - r_res_id;
    assign w_cnt_inc = r_ack_cnt + 1'b1;
    assign w_is_good = r_res_crc && (w_dist == '0);
    assign w_is_dup  = r_res_crc && (w_dist != '0) && (w_dist <= DUP_MAX);
    assign w_timeout = r_ack_pend && (r_timer == TIMER_MAX);

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_eval_good = 1'b0;
        w_eval_dup  = 1'b0;
        w_ack_done  = 1'b0;
        w_nack_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_timeout) begin
                    w_next = S_SEND_ACK;
                end else if (i_rx_id_result_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_is_good) begin
                    w_eval_good = 1'b1;
                    w_next = (w_cnt_inc == CNT_FORCE) ? S_SEND_ACK : S_IDLE;
                end else if (w_is_dup) begin
                    w_eval_dup = 1'b1;
                    w_next     = S_IDLE;
                end else if (!r_nack_flag) begin
                    w_next = S_SEND_NACK;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SEND_ACK: begin
                if (i_tx_dllp_rdy) begin
                    w_ack_done = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            S_SEND_NACK: begin
                if (i_tx_dllp_rdy) begin
                    w_nack_done = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n || !i_link_up) begin
            r_state     <= S_IDLE;
            r_exp_id    <= '0;
            r_last_good <= '0;
            r_ack_pend  <= 1'b0;
            r_ack_cnt   <= '0;
            r_timer     <= '0;
            r_nack_flag <= 1'b0;
            r_res_id    <= '0;
            r_res_crc   <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_dllp      <= '0;
        end else begin
            r_state <= w_next;
            r_rd    <= w_capture;
            r_wr    <= w_ack_done || w_nack_done;
            if (w_capture) begin
                r_res_id  <= i_rx_id_result[W-1:0];
                r_res_crc <= i_rx_id_result[W];
            end
            if (w_ack_done) begin
                r_dllp <= {DLLP_TYPE_ACK, {PADW{1'b0}}, r_last_good};
            end else if (w_nack_done) begin
                r_dllp <= {DLLP_TYPE_NACK, {PADW{1'b0}}, r_exp_id};
            end
            if (w_eval_good) begin
                r_last_good <= r_res_id;
                r_exp_id    <= r_exp_id + 1'b1;
                r_nack_flag <= 1'b0;
                r_ack_pend  <= 1'b1;
                r_ack_cnt   <= w_cnt_inc;
            end
            if (w_eval_dup) begin
                r_ack_pend <= 1'b1;
            end
            if (w_nack_done) begin
                r_nack_flag <= 1'b1;
            end
            // Timer freezes while the ACK itself is waiting for queue space.
            if (w_ack_done) begin
                r_ack_pend <= 1'b0;
                r_ack_cnt  <= '0;
                r_timer    <= '0;
            end else if (r_ack_pend && (r_state != S_SEND_ACK)
                         && (r_timer != TIMER_MAX)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign o_rx_id_result_rd = r_rd;
    assign o_tx_dllp_wr      = r_wr;
    assign o_tx_dllp         = r_dllp;
    assign o_exp_id          = r_exp_id;
    assign o_nack_active     = r_nack_flag;

endmodule

// File: tb/tb_transceiver_ack_nack_generator.sv
// Bench for transceiver_ack_nack_generator: show-ahead FIFO model on the
// result side, DLLP scoreboard on the transmit side.
module tb_transceiver_ack_nack_generator;

    localparam int W = 3;

    logic         clk;
    logic         arst_n;
    logic         link_up;
    logic         res_valid;
    logic [W:0]   res;
    logic         rd;
    logic         rdy;
    logic         wr;
    logic [15:0]  dllp;
    logic [W-1:0] exp_id;
    logic         nack;

    transceiver_ack_nack_generator dut (
        .i_clk                (clk),
        .i_arst_n             (arst_n),
        .i_link_up            (link_up),
        .i_rx_id_result_valid (res_valid),
        .i_rx_id_result       (res),
        .o_rx_id_result_rd    (rd),
        .i_tx_dllp_rdy        (rdy),
        .o_tx_dllp_wr         (wr),
        .o_tx_dllp            (dllp),
        .o_exp_id             (exp_id),
        .o_nack_active        (nack)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    typedef struct {
        logic [W:0]   res;
        bit           has;
        logic [15:0]  dllp;
        logic [W-1:0] eid;
        bit           nk;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [W:0]  fifo[$];
    logic [15:0] sb[$];

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic refresh();
        res_valid = (fifo.size() != 0);
        res = res_valid ? fifo[0] : '0;
    endtask

    task automatic push(input logic [W:0] r);
        fifo.push_back(r);
        refresh();
    endtask

    // One clock: pop on the strobe seen this cycle, then sample at edge+1.
    task automatic tick();
        logic p;
        logic [15:0] e;
        p = rd;
        @(posedge clk);
        #1;
        if (p) begin
            chk("rd_nonempty", int'(fifo.size() != 0), 1);
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        if (rd) rd_cnt++;
        if (wr) begin
            wr_cnt++;
            chk("wr_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dllp", int'(dllp), int'(e));
            end
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", sb.size(), 0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
        tick();
    endtask

    vec_t tbl[16];

    initial begin
        int t;
        int rd0;
        int wr0;

        tbl[0]  = '{4'h8, 1'b0, 16'h0000, 3'd1, 1'b0};
        tbl[1]  = '{4'h9, 1'b0, 16'h0000, 3'd2, 1'b0};
        tbl[2]  = '{4'hA, 1'b0, 16'h0000, 3'd3, 1'b0};
        tbl[3]  = '{4'hB, 1'b1, 16'h0103, 3'd4, 1'b0};
        tbl[4]  = '{4'hC, 1'b0, 16'h0000, 3'd5, 1'b0};
        tbl[5]  = '{4'hD, 1'b0, 16'h0000, 3'd6, 1'b0};
        tbl[6]  = '{4'hE, 1'b0, 16'h0000, 3'd7, 1'b0};
        tbl[7]  = '{4'hF, 1'b1, 16'h0107, 3'd0, 1'b0};
        tbl[8]  = '{4'h0, 1'b1, 16'h0200, 3'd0, 1'b1};
        tbl[9]  = '{4'h9, 1'b0, 16'h0000, 3'd0, 1'b1};
        tbl[10] = '{4'h3, 1'b0, 16'h0000, 3'd0, 1'b1};
        tbl[11] = '{4'h8, 1'b0, 16'h0000, 3'd1, 1'b0};
        tbl[12] = '{4'h8, 1'b0, 16'h0000, 3'd1, 1'b0};
        tbl[13] = '{4'hD, 1'b0, 16'h0000, 3'd1, 1'b0};
        tbl[14] = '{4'hC, 1'b1, 16'h0201, 3'd1, 1'b1};
        tbl[15] = '{4'h9, 1'b0, 16'h0000, 3'd2, 1'b0};

        arst_n = 1'b0;
        link_up = 1'b1;
        rdy = 1'b1;
        res_valid = 1'b0;
        res = '0;
        repeat (3) tick();
        chk("rst_rd", int'(rd), 0);
        chk("rst_wr", int'(wr), 0);
        chk("rst_dllp", int'(dllp), 0);
        chk("rst_exp_id", int'(exp_id), 0);
        chk("rst_nack", int'(nack), 0);
        arst_n = 1'b1;
        tick();

        // Table: coalesced ACKs, ID wrap, NACK suppression, duplicate window.
        for (int i = 0; i < 16; i++) begin
            push(tbl[i].res);
            if (tbl[i].has) sb.push_back(tbl[i].dllp);
            repeat (6) tick();
            chk($sformatf("exp_id[%0d]", i), int'(exp_id), int'(tbl[i].eid));
            chk($sformatf("nack[%0d]", i), int'(nack), int'(tbl[i].nk));
        end
        sb.push_back(16'h0101);
        drain(100);
        repeat (4) tick();
        chk("tbl_rd_count", rd_cnt, 16);
        chk("tbl_wr_count", wr_cnt, 5);

        // Single good TLP, then silence: ACK only on timeout.
        do_reset();
        push(4'h8);
        sb.push_back(16'h0100);
        wr0 = wr_cnt;
        t = 0;
        while (wr_cnt == wr0 && t < 100) begin
            tick();
            t++;
        end
        chk("timeout_wr_seen", wr_cnt - wr0, 1);
        chk("timeout_window", int'(t >= 64 && t <= 68), 1);
        chk("timeout_exp_id", int'(exp_id), 1);

        // Queue back-pressure while an ACK is waiting.
        do_reset();
        rdy = 1'b0;
        rd0 = rd_cnt;
        push(4'h8);
        push(4'h9);
        push(4'hA);
        push(4'hB);
        push(4'hC);
        sb.push_back(16'h0103);
        repeat (12) tick();
        chk("hold_rd_before", rd_cnt - rd0, 4);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        repeat (20) tick();
        chk("hold_rd", rd_cnt - rd0, 0);
        chk("hold_wr", wr_cnt - wr0, 0);
        rdy = 1'b1;
        tick();
        chk("wr_after_rdy", int'(wr), 1);
        sb.push_back(16'h0104);
        drain(120);
        chk("hold_exp_id", int'(exp_id), 5);

        // Link drop while a NACK waits for queue space.
        do_reset();
        rdy = 1'b0;
        push(4'h8);
        push(4'h9);
        push(4'h5);
        repeat (8) tick();
        chk("pre_drop_exp_id", int'(exp_id), 2);
        chk("pre_drop_nack", int'(nack), 0);
        wr0 = wr_cnt;
        link_up = 1'b0;
        rdy = 1'b1;
        tick();
        chk("drop_exp_id", int'(exp_id), 0);
        chk("drop_nack", int'(nack), 0);
        link_up = 1'b1;
        repeat (4) tick();
        chk("drop_no_wr", wr_cnt - wr0, 0);
        push(4'h8);
        sb.push_back(16'h0100);
        drain(120);
        chk("resume_exp_id", int'(exp_id), 1);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/transceiver_ack_nack_generator.md
Name: transceiver_ack_nack_generator

Overview:
- Receiver-side responder of the TLP acknowledge protocol. It pops per-TLP ID/CRC results from the receiver packet interface, tracks the expected sequence ID, and emits ACK/NACK DLLPs into the transmitter DLLP queue.
- These DLLPs drive the far-end transmitter's ID-ack/replay logic.
- Sits beside the link controller, in the 120 MHz system domain.

Parameters:
- TLP_ID_WIDTH, 3: width of the TLP sequence ID; IDs wrap modulo 2^TLP_ID_WIDTH.
- DLLP_WIDTH, 16: DLLP word width; format {type[7:0], zero pad, id[TLP_ID_WIDTH-1:0]}.
- DLLP_TYPE_ACK, 8'h01: type code of an ACK DLLP.
- DLLP_TYPE_NACK, 8'h02: type code of a NACK DLLP.
- ACK_COALESCE, 4: number of good in-order TLPs that forces an ACK.
- ACK_TIMEOUT, 64: cycles an ACK may stay pending before it is forced.

Ports:
- i_clk  in  1  system clock (120 MHz).
- i_arst_n  in  1  synchronous, active-low reset.
- i_link_up  in  1  link trained; low = synchronous flush.
- i_rx_id_result_valid  in  1  show-ahead result FIFO not empty.
- i_rx_id_result  in  TLP_ID_WIDTH+1  {crc_ok, id}.
- o_rx_id_result_rd  out  1  one-cycle pop strobe.
- i_tx_dllp_rdy  in  1  DLLP queue can accept one word.
- o_tx_dllp_wr  out  1  one-cycle DLLP write strobe.
- o_tx_dllp  out  DLLP_WIDTH  DLLP word, valid while o_tx_dllp_wr=1.
- o_exp_id  out  TLP_ID_WIDTH  next expected ID.
- o_nack_active  out  1  NACK sent, awaiting in-order TLP.

Behaviour:
- Reset (i_arst_n=0 at a clock edge):
  - all outputs 0; state IDLE.
  - exp_id=0, last_good=0, ack_pend=0, ack_cnt=0, timer=0, nack_flag=0.
- i_link_up=0 has the same effect as reset, every cycle it is low, including mid-send. A DLLP not yet written is dropped.
- States: IDLE, EVAL, SEND_ACK, SEND_NACK.
- IDLE:
  - If ack_pend and timer==ACK_TIMEOUT-1, go to SEND_ACK. This has priority over a waiting result.
  - Else if i_rx_id_result_valid: capture i_rx_id_result, assert o_rx_id_result_rd=1 for exactly the next cycle, go to EVAL.
- EVAL (uses the captured {crc_ok, id}; FIFO valid is ignored):
  - Good, crc_ok=1 and id==exp_id:
    - last_good<=id; exp_id<=exp_id+1 with wrap; nack_flag<=0; ack_pend<=1; ack_cnt<=ack_cnt+1.
    - If ack_cnt+1==ACK_COALESCE go to SEND_ACK, else IDLE.
  - crc_ok=0 (any id), or id ahead of exp_id:
    - If nack_flag=0 go to SEND_NACK with NACK id=exp_id.
    - If nack_flag=1, discard and go to IDLE.
  - Duplicate, crc_ok=1 and d=(exp_id-id) mod 2^W in 1..2^(W-1): discard, ack_pend<=1 so last_good is re-acked, go to IDLE.
  - "Ahead" means d outside 1..2^(W-1) and d!=0.
- SEND_ACK / SEND_NACK:
  - Wait while i_tx_dllp_rdy=0; o_tx_dllp_wr stays 0.
  - When i_tx_dllp_rdy=1: next cycle o_tx_dllp_wr=1 with o_tx_dllp = {DLLP_TYPE_ACK, pad, last_good} or {DLLP_TYPE_NACK, pad, exp_id}; go to IDLE.
  - After an ACK write: ack_pend=0, ack_cnt=0, timer=0.
  - After a NACK write: nack_flag=1; ack_pend, ack_cnt and timer are unchanged.
- Timer:
  - Increments every cycle while ack_pend=1 and state != SEND_ACK.
  - Saturates at ACK_TIMEOUT-1.
  - Clears with ack_pend.
- Throughput: minimum 2 cycles per result without a DLLP; 3 cycles plus rdy wait with a DLLP.
- o_tx_dllp holds its last value when o_tx_dllp_wr=0.
- ID wrap: exp_id 7 -> 0 for W=3; the duplicate window wraps the same way.
- o_exp_id=exp_id; o_nack_active=nack_flag.

Test Plan:
- Reset then results {1,0}..{1,3} with rdy=1 -> four rd pulses; one wr, o_tx_dllp=16'h0103; o_exp_id=4.
- Single {1,0}, then no input -> ACK 16'h0100 written 64 cycles after ack_pend set; no earlier wr.
- {1,0}, {0,1}, {1,2}, {1,1} -> NACK 16'h0201 once; {1,2} dropped silently; {1,1} clears o_nack_active; exp_id=2.
- exp_id=7, results {1,7}, {1,0}, {1,6} -> exp_id wraps 7->0->1; {1,6} treated as duplicate; ACK id=0 sent on timeout.
- Hold rdy=0 in SEND_ACK for 20 cycles -> no wr and no further rd; rdy=1 -> exactly one wr one cycle later.
- Drop i_link_up while in SEND_NACK -> no wr; o_exp_id=0, o_nack_active=0 next cycle; resumes cleanly when link is up again.
